// File: rtl/angle_update_sched_if.sv
// Host/steering-controller signal bundle for the angle update scheduler.
// master = host register block plus pwm_ctrl side, slave = the scheduler.
interface angle_update_sched_if;
    logic        enable;
    logic [47:0] target_angle_in;
    logic [3:0]  target_valid;
    logic [47:0] ch_target_angle;
    logic [3:0]  ch_angle_update;
    logic [3:0]  ch_angle_done;
    logic [3:0]  clear_timeout;
    logic [3:0]  timeout_flag;
    logic        busy;
    logic [1:0]  active_ch;

    modport master (
        output enable, target_angle_in, target_valid, ch_angle_done, clear_timeout,
        input  ch_target_angle, ch_angle_update, timeout_flag, busy, active_ch
    );

    modport slave (
        input  enable, target_angle_in, target_valid, ch_angle_done, clear_timeout,
        output ch_target_angle, ch_angle_update, timeout_flag, busy, active_ch
    );
endinterface

// File: rtl/angle_update_sched.sv
// Round-robin scheduler serializing angle updates to four steering controllers:
// one channel in flight at a time, finished by a done rising edge or a timeout.
module angle_update_sched #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    angle_update_sched_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [11:0] r_shadow [4];
    logic        r_pending [4];
    logic [11:0] r_angle [4];
    logic [3:0]  r_ch_angle_update;
    logic [3:0]  r_timeout_flag;
    logic [3:0]  r_done_d;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_active_ch;
    logic [23:0] r_wait_cnt;
    logic        r_busy;

    logic [3:0]  w_pending;
    logic [7:0]  w_pend_dbl;
    logic [3:0]  w_pend_rot;
    logic [1:0]  w_grant_off;
    logic [1:0]  w_grant_ch;
    logic        w_grant;
    logic        w_done_rise;
    logic        w_timeout_hit;
    logic        w_timeout_set;
    logic [3:0]  w_timeout_set_vec;

    // Rotate pending so offset 0 is rr_ptr, then take the lowest set offset.
    assign w_pend_dbl = {w_pending, w_pending};
    assign w_pend_rot = w_pend_dbl[r_rr_ptr +: 4];

    always_comb begin
        w_grant_off = 2'd0;
        casez (w_pend_rot)
            4'b???1: w_grant_off = 2'd0;
            4'b??10: w_grant_off = 2'd1;
            4'b?100: w_grant_off = 2'd2;
            default: w_grant_off = 2'd3;
        endcase
    end

    assign w_grant_ch  = r_rr_ptr + w_grant_off;
    assign w_grant     = (r_state == IDLE) && bus.enable && (|w_pending);

    // A done level already high on WAIT entry is masked by done_d.
    assign w_done_rise   = bus.ch_angle_done[r_active_ch] & ~r_done_d[r_active_ch];
    assign w_timeout_hit = (r_wait_cnt == TIMEOUT_CYCLES - 24'd1);
    assign w_timeout_set = (r_state == WAIT) && !w_done_rise && w_timeout_hit;
    assign w_timeout_set_vec = w_timeout_set ? (4'b0001 << r_active_ch) : 4'b0000;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_done_rise || w_timeout_hit) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ch_angle_update <= 4'b0000;
            r_active_ch       <= 2'd0;
            r_rr_ptr          <= 2'd0;
            r_wait_cnt        <= 24'd0;
            r_done_d          <= 4'b0000;
            r_busy            <= 1'b0;
            r_timeout_flag    <= 4'b0000;
        end else begin
            r_ch_angle_update <= w_grant ? (4'b0001 << w_grant_ch) : 4'b0000;
            if (w_grant)
                r_active_ch <= w_grant_ch;
            if (r_state == DONE)
                r_rr_ptr <= r_active_ch + 2'd1;
            if (r_state == ISSUE)
                r_wait_cnt <= 24'd0;
            else if (r_state == WAIT)
                r_wait_cnt <= r_wait_cnt + 24'd1;
            r_done_d       <= bus.ch_angle_done;
            r_busy         <= (w_state_next != IDLE);
            // A set wins over a clear landing on the same cycle.
            r_timeout_flag <= (r_timeout_flag & ~bus.clear_timeout) | w_timeout_set_vec;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_shadow[gi]  <= 12'd0;
                    r_pending[gi] <= 1'b0;
                    r_angle[gi]   <= 12'd0;
                end else begin
                    // A strobe during ISSUE keeps pending set so the new value gets its own grant.
                    if (bus.target_valid[gi]) begin
                        r_shadow[gi]  <= bus.target_angle_in[12*gi +: 12];
                        r_pending[gi] <= 1'b1;
                    end else if (r_state == ISSUE && r_active_ch == 2'(gi)) begin
                        r_pending[gi] <= 1'b0;
                    end
                    if (w_grant && w_grant_ch == 2'(gi))
                        r_angle[gi] <= r_shadow[gi];
                end
            end

            assign w_pending[gi]                 = r_pending[gi];
            assign bus.ch_target_angle[12*gi +: 12] = r_angle[gi];
        end
    endgenerate

    assign bus.ch_angle_update = r_ch_angle_update;
    assign bus.timeout_flag    = r_timeout_flag;
    assign bus.busy            = r_busy;
    assign bus.active_ch       = r_active_ch;

endmodule

// File: doc/angle_update_sched.md
# angle_update_sched

Round-robin scheduler that sequences angle updates to four swerve-module steering controllers (`pwm_ctrl` instances). Per-channel target angles from the host register interface are buffered in shadow registers. At most one channel is granted at a time: the scheduler presents its target, pulses `angle_update`, then waits for that channel's `angle_done` or a timeout. Only one steering motor slews at a time, which bounds peak current and serializes encoder I2C traffic.

## Interface
- `TIMEOUT_CYCLES`, 24'd5_000_000: cycles in WAIT before a channel is abandoned (100 ms at 50 MHz).
- `clock`  in  1  main clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  allows new grants; low blocks grants only, in-flight channel completes
- `target_angle_in`  in  48  four 12-bit angles; ch n = bits [12n+11:12n]
- `target_valid`  in  4  1-cycle strobe per channel; latches that channel's slice
- `ch_target_angle`  out  48  registered angle to each `pwm_ctrl`; same packing
- `ch_angle_update`  out  4  one-hot 1-cycle update pulse
- `ch_angle_done`  in  4  `angle_done` from each `pwm_ctrl` (level)
- `clear_timeout`  in  4  1-cycle strobe; clears matching `timeout_flag` bits
- `timeout_flag`  out  4  sticky; set when a channel times out
- `busy`  out  1  high in ISSUE, WAIT, DONE
- `active_ch`  out  2  channel granted or last granted

## Operation
- **Shadow/pending:** `target_valid[n]` writes the `target_angle_in` slice into shadow[n] and sets pending[n]. Repeat strobes before service overwrite the shadow; last value wins, with one service only.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If `enable` and any pending bit is set, select the first pending channel searching upward (mod 4) from rr_ptr, then go to ISSUE.
  - On that same edge: `ch_target_angle[ch]` <= shadow[ch]; `ch_angle_update[ch]` <= 1; `active_ch` <= ch.
- **ISSUE:** lasts 1 cycle, with the update pulse high. Clear pending[ch] unless `target_valid[ch]` is high this cycle; in that case pending stays set and the new shadow is served in a later grant. Go to WAIT.
- **WAIT:**
  - done_d = `ch_angle_done` registered each cycle.
  - Completion is the rising edge on the active channel (`ch_angle_done[ch]` & ~done_d[ch]) → DONE.
  - Else if the counter equals `TIMEOUT_CYCLES`-1 → set `timeout_flag[ch]`, go to DONE.
  - Counter is 24-bit, zeroed on WAIT entry, and increments each WAIT cycle.
  - Done and timeout in the same cycle: done wins, no flag.
- **DONE:** 1 cycle; rr_ptr <= ch+1 (mod 4); go to IDLE.
- **Non-active channels:** `ch_target_angle` slices hold their last value. New strobes during WAIT only update shadow/pending.
- **Timeout flags:** `clear_timeout[n]` clears `timeout_flag[n]`. A set and a clear for the same bit in the same cycle leaves the bit set.
- **Reset (any time, including mid-WAIT):**
  - State → IDLE; `ch_target_angle`, shadow, pending, `ch_angle_update`, `timeout_flag` → 0.
  - rr_ptr → 0; `active_ch` → 0; `busy` → 0; counter → 0; done_d → 0.

## Timing
- `target_valid[n]` in cycle 0 → pending[n] visible in cycle 1 → `ch_angle_update[n]` high in cycle 2 (exactly 1 cycle), when idle and enabled.
- `ch_target_angle[n]` changes on the same edge the pulse rises, then holds.
- WAIT starts in cycle 3. A done rising edge sampled in WAIT cycle k gives DONE in k+1, IDLE in k+2, and the next channel's update in k+3 at the earliest.
- Timeout: the flag is set on the edge ending the `TIMEOUT_CYCLES`-th WAIT cycle.
- `busy` is a registered decode of the state; it has no combinational path from inputs.
- A done that is already high on WAIT entry does not count; a fresh rising edge is required.

## Test plan
- Single channel: strobe ch2 with 12'h0B4 → ch2 pulse 2 cycles later, `ch_target_angle[35:24]`=12'h0B4. Raise `ch_angle_done[2]` 10 cycles later → `busy` low 2 cycles after the done sample; no flag.
- Round-robin: strobe all four in one cycle with rr_ptr=0 → grant order 0,1,2,3, each granted only after the previous done. After the sequence rr_ptr=0, so a new ch3+ch1 strobe grants ch1 first (rr_ptr=0 searches upward).
- Timeout (`TIMEOUT_CYCLES`=16): strobe ch1, never assert done → `timeout_flag`=4'b0010 after 16 WAIT cycles and the next pending channel proceeds. `clear_timeout`=4'b0010 → flag 0.
- Re-strobe during WAIT: ch0 active, strobe ch0 with 12'h123 → after done, ch0 is regranted with 12'h123. Re-strobe exactly in ISSUE → pending stays set and ch0 is regranted.
- `enable`=0 with pending ch3 → no pulse; `enable`=1 → pulse 1 cycle later. `enable` dropped mid-WAIT → the current channel completes normally.
- Async reset asserted mid-WAIT → all outputs 0 immediately. After release, the old pending is gone and no pulse occurs without a new strobe.
